// File: rtl/bus_req_arbiter.sv
// Round-robin arbiter sharing one line-request port between the UART loader (u_*)
// and the D-cache (d_*), with per-requester pending slots, response routing and a watchdog.
module bus_req_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 128,
  parameter int MW        = 16,
  parameter int TO_CYCLES = 4096
) (
  input  logic          clk,
  input  logic          rst,
  // UART loader
  input  logic          u_wstart_rq,
  input  logic [AW-1:0] u_win_addr,
  input  logic [DW-1:0] u_in_wdata,
  input  logic [MW-1:0] u_in_mask,
  input  logic          u_rstart_rq,
  input  logic [AW-1:0] u_rin_addr,
  output logic          u_finish_wresp,
  output logic [DW-1:0] u_rdat_m_data,
  output logic          u_rdat_m_valid,
  output logic          u_finish_mrd,
  // D-cache
  input  logic          d_wstart_rq,
  input  logic [AW-1:0] d_win_addr,
  input  logic [DW-1:0] d_in_wdata,
  input  logic [MW-1:0] d_in_mask,
  input  logic          d_rstart_rq,
  input  logic [AW-1:0] d_rin_addr,
  output logic          d_finish_wresp,
  output logic [DW-1:0] d_rdat_m_data,
  output logic          d_rdat_m_valid,
  output logic          d_finish_mrd,
  // downstream requester channel
  output logic          m_wstart_rq,
  output logic [AW-1:0] m_win_addr,
  output logic [DW-1:0] m_in_wdata,
  output logic [MW-1:0] m_in_mask,
  output logic          m_rstart_rq,
  output logic [AW-1:0] m_rin_addr,
  input  logic          m_finish_wresp,
  input  logic [DW-1:0] m_rdat_m_data,
  input  logic          m_rdat_m_valid,
  input  logic          m_finish_mrd,
  // status
  output logic          busy,
  output logic [1:0]    ovf_err,
  output logic          timeout_err
);

  typedef enum logic [1:0] {IDLE, WAIT_W, WAIT_R} state_t;

  localparam int CW = $clog2(TO_CYCLES + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TO_CYCLES - 1);

  state_t state_q, state_d;
  logic   owner_q, owner_d;          // 0 = UART, 1 = D-cache
  logic   lastGrant_q, lastGrant_d;
  logic [CW-1:0] wdCnt_q, wdCnt_d;

  logic          uWrValid_q, uWrValid_d, uRdValid_q, uRdValid_d;
  logic [AW-1:0] uWrAddr_q, uWrAddr_d, uRdAddr_q, uRdAddr_d;
  logic [DW-1:0] uWrData_q, uWrData_d;
  logic [MW-1:0] uWrMask_q, uWrMask_d;
  logic          dWrValid_q, dWrValid_d, dRdValid_q, dRdValid_d;
  logic [AW-1:0] dWrAddr_q, dWrAddr_d, dRdAddr_q, dRdAddr_d;
  logic [DW-1:0] dWrData_q, dWrData_d;
  logic [MW-1:0] dWrMask_q, dWrMask_d;

  logic          mWstart_q, mWstart_d, mRstart_q, mRstart_d;
  logic [AW-1:0] mWinAddr_q, mWinAddr_d, mRinAddr_q, mRinAddr_d;
  logic [DW-1:0] mInWdata_q, mInWdata_d;
  logic [MW-1:0] mInMask_q, mInMask_d;

  logic          uFinWresp_q, uFinWresp_d, uRdValid2_q, uRdValid2_d, uFinMrd_q, uFinMrd_d;
  logic          dFinWresp_q, dFinWresp_d, dRdValid2_q, dRdValid2_d, dFinMrd_q, dFinMrd_d;
  logic [DW-1:0] uRdData_q, uRdData_d, dRdData_q, dRdData_d;
  logic [1:0]    ovfErr_q, ovfErr_d;
  logic          toErr_q, toErr_d;

  logic uPend, dPend, pickD, pickWr, grant;
  logic wdHit, wDone, rDone, timeout;
  logic uWrTake, uRdTake, dWrTake, dRdTake;
  logic uWrBusy, uRdBusy, dWrBusy, dRdBusy;

  // Arbitration: on a tie the requester that was not granted last wins; writes before reads.
  assign uPend   = uWrValid_q | uRdValid_q;
  assign dPend   = dWrValid_q | dRdValid_q;
  assign pickD   = dPend & (~uPend | ~lastGrant_q);
  assign pickWr  = pickD ? dWrValid_q : uWrValid_q;
  assign grant   = (state_q == IDLE) & (uPend | dPend);

  assign wdHit   = (wdCnt_q == WD_LAST);
  assign wDone   = (state_q == WAIT_W) & (m_finish_wresp | wdHit);
  assign rDone   = (state_q == WAIT_R) & (m_finish_mrd | wdHit);
  assign timeout = ((state_q == WAIT_W) & wdHit & ~m_finish_wresp) |
                   ((state_q == WAIT_R) & wdHit & ~m_finish_mrd);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (uPend | dPend) state_d = pickWr ? WAIT_W : WAIT_R;
      WAIT_W:  if (wDone) state_d = IDLE;
      WAIT_R:  if (rDone) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A pulse is dropped while its slot is full or while that same type is still in flight for it.
  assign uWrBusy = (state_q == WAIT_W) & ~owner_q & ~wDone;
  assign uRdBusy = (state_q == WAIT_R) & ~owner_q & ~rDone;
  assign dWrBusy = (state_q == WAIT_W) &  owner_q & ~wDone;
  assign dRdBusy = (state_q == WAIT_R) &  owner_q & ~rDone;
  assign uWrTake = u_wstart_rq & ~uWrValid_q & ~uWrBusy;
  assign uRdTake = u_rstart_rq & ~uRdValid_q & ~uRdBusy;
  assign dWrTake = d_wstart_rq & ~dWrValid_q & ~dWrBusy;
  assign dRdTake = d_rstart_rq & ~dRdValid_q & ~dRdBusy;

  always_comb begin
    uWrValid_d = uWrValid_q;
    uWrAddr_d  = uWrAddr_q;
    uWrData_d  = uWrData_q;
    uWrMask_d  = uWrMask_q;
    uRdValid_d = uRdValid_q;
    uRdAddr_d  = uRdAddr_q;
    dWrValid_d = dWrValid_q;
    dWrAddr_d  = dWrAddr_q;
    dWrData_d  = dWrData_q;
    dWrMask_d  = dWrMask_q;
    dRdValid_d = dRdValid_q;
    dRdAddr_d  = dRdAddr_q;
    if (grant & ~pickD &  pickWr) uWrValid_d = 1'b0;
    if (grant & ~pickD & ~pickWr) uRdValid_d = 1'b0;
    if (grant &  pickD &  pickWr) dWrValid_d = 1'b0;
    if (grant &  pickD & ~pickWr) dRdValid_d = 1'b0;
    if (uWrTake) begin
      uWrValid_d = 1'b1;
      uWrAddr_d  = u_win_addr;
      uWrData_d  = u_in_wdata;
      uWrMask_d  = u_in_mask;
    end
    if (uRdTake) begin
      uRdValid_d = 1'b1;
      uRdAddr_d  = u_rin_addr;
    end
    if (dWrTake) begin
      dWrValid_d = 1'b1;
      dWrAddr_d  = d_win_addr;
      dWrData_d  = d_in_wdata;
      dWrMask_d  = d_in_mask;
    end
    if (dRdTake) begin
      dRdValid_d = 1'b1;
      dRdAddr_d  = d_rin_addr;
    end
  end

  always_comb begin
    mWstart_d   = grant & pickWr;
    mRstart_d   = grant & ~pickWr;
    mWinAddr_d  = mWinAddr_q;
    mInWdata_d  = mInWdata_q;
    mInMask_d   = mInMask_q;
    mRinAddr_d  = mRinAddr_q;
    owner_d     = owner_q;
    lastGrant_d = lastGrant_q;
    if (grant) begin
      owner_d     = pickD;
      lastGrant_d = pickD;
    end
    if (grant & pickWr) begin
      mWinAddr_d = pickD ? dWrAddr_q : uWrAddr_q;
      mInWdata_d = pickD ? dWrData_q : uWrData_q;
      mInMask_d  = pickD ? dWrMask_q : uWrMask_q;
    end
    if (grant & ~pickWr) mRinAddr_d = pickD ? dRdAddr_q : uRdAddr_q;
    wdCnt_d     = (state_q == IDLE) ? '0 : wdCnt_q + CW'(1);
    uFinWresp_d = wDone & ~owner_q;
    dFinWresp_d = wDone &  owner_q;
    uFinMrd_d   = rDone & ~owner_q;
    dFinMrd_d   = rDone &  owner_q;
    uRdValid2_d = (state_q == WAIT_R) & ~owner_q & m_rdat_m_valid;
    dRdValid2_d = (state_q == WAIT_R) &  owner_q & m_rdat_m_valid;
    uRdData_d   = uRdValid2_d ? m_rdat_m_data : '0;
    dRdData_d   = dRdValid2_d ? m_rdat_m_data : '0;
    ovfErr_d    = ovfErr_q | {d_wstart_rq & ~dWrTake | d_rstart_rq & ~dRdTake,
                              u_wstart_rq & ~uWrTake | u_rstart_rq & ~uRdTake};
    toErr_d     = toErr_q | timeout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      wdCnt_q     <= '0;
      uWrValid_q  <= 1'b0;
      uWrAddr_q   <= '0;
      uWrData_q   <= '0;
      uWrMask_q   <= '0;
      uRdValid_q  <= 1'b0;
      uRdAddr_q   <= '0;
      dWrValid_q  <= 1'b0;
      dWrAddr_q   <= '0;
      dWrData_q   <= '0;
      dWrMask_q   <= '0;
      dRdValid_q  <= 1'b0;
      dRdAddr_q   <= '0;
      mWstart_q   <= 1'b0;
      mRstart_q   <= 1'b0;
      mWinAddr_q  <= '0;
      mInWdata_q  <= '0;
      mInMask_q   <= '0;
      mRinAddr_q  <= '0;
      uFinWresp_q <= 1'b0;
      dFinWresp_q <= 1'b0;
      uFinMrd_q   <= 1'b0;
      dFinMrd_q   <= 1'b0;
      uRdValid2_q <= 1'b0;
      dRdValid2_q <= 1'b0;
      uRdData_q   <= '0;
      dRdData_q   <= '0;
      ovfErr_q    <= '0;
      toErr_q     <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      lastGrant_q <= lastGrant_d;
      wdCnt_q     <= wdCnt_d;
      uWrValid_q  <= uWrValid_d;
      uWrAddr_q   <= uWrAddr_d;
      uWrData_q   <= uWrData_d;
      uWrMask_q   <= uWrMask_d;
      uRdValid_q  <= uRdValid_d;
      uRdAddr_q   <= uRdAddr_d;
      dWrValid_q  <= dWrValid_d;
      dWrAddr_q   <= dWrAddr_d;
      dWrData_q   <= dWrData_d;
      dWrMask_q   <= dWrMask_d;
      dRdValid_q  <= dRdValid_d;
      dRdAddr_q   <= dRdAddr_d;
      mWstart_q   <= mWstart_d;
      mRstart_q   <= mRstart_d;
      mWinAddr_q  <= mWinAddr_d;
      mInWdata_q  <= mInWdata_d;
      mInMask_q   <= mInMask_d;
      mRinAddr_q  <= mRinAddr_d;
      uFinWresp_q <= uFinWresp_d;
      dFinWresp_q <= dFinWresp_d;
      uFinMrd_q   <= uFinMrd_d;
      dFinMrd_q   <= dFinMrd_d;
      uRdValid2_q <= uRdValid2_d;
      dRdValid2_q <= dRdValid2_d;
      uRdData_q   <= uRdData_d;
      dRdData_q   <= dRdData_d;
      ovfErr_q    <= ovfErr_d;
      toErr_q     <= toErr_d;
    end
  end

  assign m_wstart_rq    = mWstart_q;
  assign m_win_addr     = mWinAddr_q;
  assign m_in_wdata     = mInWdata_q;
  assign m_in_mask      = mInMask_q;
  assign m_rstart_rq    = mRstart_q;
  assign m_rin_addr     = mRinAddr_q;
  assign u_finish_wresp = uFinWresp_q;
  assign u_rdat_m_data  = uRdData_q;
  assign u_rdat_m_valid = uRdValid2_q;
  assign u_finish_mrd   = uFinMrd_q;
  assign d_finish_wresp = dFinWresp_q;
  assign d_rdat_m_data  = dRdData_q;
  assign d_rdat_m_valid = dRdValid2_q;
  assign d_finish_mrd   = dFinMrd_q;
  assign busy           = (state_q != IDLE);
  assign ovf_err        = ovfErr_q;
  assign timeout_err    = toErr_q;

endmodule
